// File: rtl/data_mem_seq_if.sv
// Bus bundle for data_mem_seq: address/data strobes in, registered read response and status out.
interface data_mem_seq_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic [AW-1:0] AD;
    logic [DW-1:0] WD;
    logic          MW;
    logic          MR;
    logic          REINIT;
    logic [DW-1:0] RD;
    logic          RVALID;
    logic          ERR;
    logic          READY;
    logic          BUSY;

    modport master (output AD, WD, MW, MR, REINIT,
                    input  RD, RVALID, ERR, READY, BUSY);
    modport slave  (input  AD, WD, MW, MR, REINIT,
                    output RD, RVALID, ERR, READY, BUSY);
endinterface

// File: rtl/data_mem_seq.sv
// Single-port data memory with sequenced pattern init after reset/REINIT and a registered read.
// Optional MEM_WR_FWD_EN: same-address read+write returns WD (write-first); default is read-first.
module data_mem_seq #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input logic           CLK,
    input logic           RESET_N,
    data_mem_seq_if.slave bus
);
    typedef enum logic {INIT, IDLE} state_t;

    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  LAST    = CW'(DEPTH - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  HALF_C  = CW'(DEPTH / 2);
    localparam logic [DW-1:0]  HALF_D  = DW'(DEPTH / 2);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q, rd_nx, pat;
    logic          rvalid_q, err_q;
    logic          in_range, acc_rd, acc_wr;

    always_comb begin
        in_range = ({1'b0, bus.AD} < DEPTH_C);
        acc_rd   = (state == IDLE) && bus.MR;
        acc_wr   = (state == IDLE) && bus.MW;
        pat      = (cnt < HALF_C) ? DW'(cnt) : HALF_D - DW'(cnt);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            INIT: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            IDLE: begin
                if (bus.REINIT) begin
                    state_nx = INIT;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        rd_nx = '0;
        if (in_range) begin
`ifdef MEM_WR_FWD_EN
            rd_nx = acc_wr ? bus.WD : mem[bus.AD];
`else
            rd_nx = mem[bus.AD];
`endif
        end
    end

    // Array has no reset; INIT rewrites every word (cnt < DEPTH always holds here).
    always_ff @(posedge CLK) begin
        if (state == INIT)
            mem[cnt[AW-1:0]] <= pat;
        else if (acc_wr && in_range)
            mem[bus.AD] <= bus.WD;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= acc_rd;
            err_q    <= (acc_rd || acc_wr) && !in_range;
            if (acc_rd)
                rd_q <= rd_nx;
        end
    end

    assign bus.RD     = rd_q;
    assign bus.RVALID = rvalid_q;
    assign bus.ERR    = err_q;
    assign bus.READY  = (state == IDLE);
    assign bus.BUSY   = (state == INIT);
endmodule
